// File: rtl/bcd_pkg.sv
// Shared BCD helpers for the decade counters: digit width, maximum digit,
// and the per-nibble clamp and decrement rules.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Any non-decimal nibble (A..F) is treated as the largest legal digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] nibble);
    return (nibble == '0) ? BCD_MAX : nibble - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD decade of the down-counter: reset, clamped load, or decrement
// with 0 -> 9 borrow.
module bcd_digit_dn
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             dec,
  output logic [BCD_W-1:0] d,
  output logic             is_zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      d <= '0;
    end else if (ld) begin
      d <= bcd_clamp(ld_val);
    end else if (dec) begin
      d <= bcd_dec(d);
    end
  end

  assign is_zero = (d == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-decade BCD countdown timer with borrow enables, zero flag and a
// one-cycle done pulse on the 1 -> 0 decrement.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int WRAP   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic [BCD_W*DIGITS-1:0]               din,
  input  logic                                  en,
  output logic [BCD_W*DIGITS-1:0]               q,
  output logic [((DIGITS > 1) ? DIGITS-2 : 0):0] ena,
  output logic                                  zero,
  output logic                                  done
);

  localparam logic [BCD_W*DIGITS-1:0] QONE = (BCD_W*DIGITS)'(1);

  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] low_zero;
  logic [DIGITS-1:0] dec;
  logic              step;
  logic              done_nxt;

  assign zero = &is_zero;

  // A decrement happens only when no higher-priority action claims the edge
  // and, without wrap, the count is not already parked at zero.
  assign step = en & ~load & ~rst & ((WRAP != 0) | ~zero);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign low_zero[i] = 1'b1;
    end else begin : g_upper
      assign low_zero[i] = &is_zero[i-1:0];
    end

    assign dec[i] = step & low_zero[i];

    bcd_digit_dn u_digit (
      .clk     (clk),
      .rst     (rst),
      .ld      (load),
      .ld_val  (din[BCD_W*i +: BCD_W]),
      .dec     (dec[i]),
      .d       (q[BCD_W*i +: BCD_W]),
      .is_zero (is_zero[i])
    );
  end

  if (DIGITS > 1) begin : g_ena
    assign ena = dec[DIGITS-1:1];
  end else begin : g_no_ena
    assign ena = 1'b0;
  end

  assign done_nxt = step & (q == QONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter: a hold-at-zero and a wrapping instance share
// the same stimulus and are checked against a decimal-arithmetic model.
module tb_bcd_down_counter;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int MODN   = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] din = '0;

  logic [W-1:0] q_hold, q_wrap;
  logic [1:0]   ena_hold, ena_wrap;
  logic         zero_hold, zero_wrap, done_hold, done_wrap;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] exp_q[$];
  int             m_v[2];
  logic           m_done[2];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(DIGITS), .WRAP(0)) u_hold (
    .clk(clk), .rst(rst), .load(load), .din(din), .en(en),
    .q(q_hold), .ena(ena_hold), .zero(zero_hold), .done(done_hold)
  );

  bcd_down_counter #(.DIGITS(DIGITS), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .load(load), .din(din), .en(en),
    .q(q_wrap), .ena(ena_wrap), .zero(zero_wrap), .done(done_wrap)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // ---------------- reference model (plain decimal arithmetic) ----------------
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [W-1:0] d);
    int v, p, n;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n = int'(d[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  // Digit i moves on this edge iff the count changes and the value below it is 0.
  function automatic logic [1:0] ena_model(input int v, input bit wrap,
                                           input logic r, input logic l, input logic e);
    logic [1:0] a;
    int p;
    a = '0;
    if (r || l || !e) return a;
    if (v == 0 && !wrap) return a;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      a[i-1] = ((v % p) == 0);
      p = p * 10;
    end
    return a;
  endfunction

  task automatic model_edge(input int k, input bit wrap,
                            input logic r, input logic l, input logic [W-1:0] d, input logic e);
    if (r) begin
      m_v[k] = 0;
      m_done[k] = 1'b0;
    end else if (l) begin
      m_v[k] = load_value(d);
      m_done[k] = 1'b0;
    end else if (e) begin
      if (m_v[k] == 0) begin
        m_v[k] = wrap ? MODN - 1 : 0;
        m_done[k] = 1'b0;
      end else begin
        m_done[k] = (m_v[k] == 1);
        m_v[k] = m_v[k] - 1;
      end
    end else begin
      m_done[k] = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic l, input logic [W-1:0] d, input logic e);
    logic [2*W-1:0] want;
    @(negedge clk);
    rst = r; load = l; din = d; en = e;
    #1;
    check("ena_hold", 32'(ena_hold), 32'(ena_model(m_v[0], 1'b0, r, l, e)));
    check("ena_wrap", 32'(ena_wrap), 32'(ena_model(m_v[1], 1'b1, r, l, e)));
    model_edge(0, 1'b0, r, l, d, e);
    model_edge(1, 1'b1, r, l, d, e);
    exp_q.push_back({to_bcd(m_v[1]), to_bcd(m_v[0])});
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check("q_hold", 32'(q_hold), 32'(want[W-1:0]));
    check("q_wrap", 32'(q_wrap), 32'(want[2*W-1:W]));
    check("zero_hold", 32'(zero_hold), 32'(m_v[0] == 0));
    check("zero_wrap", 32'(zero_wrap), 32'(m_v[1] == 0));
    check("done_hold", 32'(done_hold), 32'(m_done[0]));
    check("done_wrap", 32'(done_wrap), 32'(m_done[1]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_v[0] = 0; m_v[1] = 0;
    m_done[0] = 1'b0; m_done[1] = 1'b0;

    // reset overrides load and en
    drive(1'b1, 1'b1, 12'h123, 1'b1);
    drive(1'b1, 1'b1, 12'h123, 1'b1);
    check("rst_q", 32'(q_hold), 32'h000);
    check("rst_zero", 32'(zero_hold), 32'h1);
    check("rst_ena", 32'(ena_hold), 32'h0);

    // load then count through the tens/hundreds borrow down to zero
    drive(1'b0, 1'b1, 12'h102, 1'b0);
    check("load_102", 32'(q_hold), 32'h102);
    repeat (3) drive(1'b0, 1'b0, '0, 1'b1);
    check("borrow_099", 32'(q_hold), 32'h099);
    repeat (99) drive(1'b0, 1'b0, '0, 1'b1);
    check("reach_000", 32'(q_hold), 32'h000);
    check("done_pulse", 32'(done_hold), 32'h1);

    // zero with en: hold vs wrap
    repeat (3) drive(1'b0, 1'b0, '0, 1'b1);
    check("hold_000", 32'(q_hold), 32'h000);
    check("hold_done", 32'(done_hold), 32'h0);

    // clamp, load over en, reset over load
    drive(1'b0, 1'b1, 12'hA5F, 1'b1);
    check("clamp_959", 32'(q_hold), 32'h959);
    drive(1'b1, 1'b1, 12'h456, 1'b0);
    check("rst_over_load", 32'(q_hold), 32'h000);

    // enable gating
    drive(1'b0, 1'b1, 12'h010, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("gate_008", 32'(q_hold), 32'h008);

    // reset on the 1 -> 0 edge gives no pulse; loading 0 gives none either
    drive(1'b0, 1'b1, 12'h001, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1);
    check("midrst_done", 32'(done_hold), 32'h0);
    drive(1'b0, 1'b1, 12'h000, 1'b1);
    check("load0_done", 32'(done_hold), 32'h0);

    // randomized traffic, biased toward small loads so the end of count is hit often
    for (int n = 0; n < 600; n++) begin
      logic r, l, e;
      logic [W-1:0] d;
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) d = W'($urandom);
      else d = to_bcd(int'($urandom_range(0, 12)));
      drive(r, l, d, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
